// File: rtl/regfile_view_ctrl.sv
// Register-file viewer: debounced switch/auto-scan register selection driving a
// request/ack debug read port, with a latched display value and a sticky timeout flag.
module regfile_view_ctrl #(
  parameter int unsigned SCAN_DIV    = 50000000,
  parameter int unsigned DEB_CYCLES  = 1000000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  switches,
  input  logic        mode_auto,
  output logic        dbg_req,
  output logic [4:0]  dbg_addr,
  input  logic        dbg_ack,
  input  logic [31:0] dbg_data,
  output logic [4:0]  disp_idx,
  output logic [31:0] disp_data,
  output logic        disp_valid,
  output logic        rd_err
);

  localparam int unsigned TickW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DebW  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned ToW   = $clog2(ACK_TIMEOUT + 1);

  localparam logic [TickW-1:0] TickMax = TickW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0]  DebMax  = DebW'(DEB_CYCLES);
  localparam logic [ToW-1:0]   ToMax   = ToW'(ACK_TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  // Input synchronizers; mode_prev_q only serves the rising-edge detect.
  logic [4:0] sw_meta_q, sw_sync_q;
  logic       mode_meta_q, mode_sync_q, mode_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      mode_meta_q <= 1'b0;
      mode_sync_q <= 1'b0;
      mode_prev_q <= 1'b0;
    end else begin
      sw_meta_q   <= switches;
      sw_sync_q   <= sw_meta_q;
      mode_meta_q <= mode_auto;
      mode_sync_q <= mode_meta_q;
      mode_prev_q <= mode_sync_q;
    end
  end

  logic mode_rise;
  assign mode_rise = mode_sync_q & ~mode_prev_q;

  // Debounce: deb_cnt counts consecutive cycles the synchronized value has held.
  logic [4:0]      deb_val_q, sel_idx_q, sel_idx_d;
  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;

  always_comb begin
    deb_cnt_d = DebW'(1);
    if (sw_sync_q == deb_val_q) begin
      if (deb_cnt_q != DebMax) begin
        deb_cnt_d = deb_cnt_q + DebW'(1);
      end else begin
        deb_cnt_d = deb_cnt_q;
      end
    end
    sel_idx_d = sel_idx_q;
    if (deb_cnt_d == DebMax) begin
      sel_idx_d = sw_sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_val_q <= '0;
      deb_cnt_q <= '0;
      sel_idx_q <= '0;
    end else begin
      deb_val_q <= sw_sync_q;
      deb_cnt_q <= deb_cnt_d;
      sel_idx_q <= sel_idx_d;
    end
  end

  // Scan/refresh tick; entering auto mode restarts the period.
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  assign tick = (tick_cnt_q == TickMax);

  always_comb begin
    if (mode_rise || tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TickW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Target selection and refresh requests.
  logic [4:0] target_q, target_d;
  logic       refresh_set;

  always_comb begin
    target_d    = target_q;
    refresh_set = 1'b0;
    if (mode_rise) begin
      target_d    = sel_idx_d;
      refresh_set = 1'b1;
    end else if (mode_sync_q) begin
      if (tick) begin
        target_d    = target_q + 5'd1;
        refresh_set = 1'b1;
      end
    end else begin
      target_d = sel_idx_d;
      if (tick || (sel_idx_d != target_q)) begin
        refresh_set = 1'b1;
      end
    end
  end

  // Read FSM.
  state_e         state_q, state_d;
  logic           pending_q, pending_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic [4:0]     dbg_addr_q, dbg_addr_d;
  logic [4:0]     disp_idx_q, disp_idx_d;
  logic [31:0]    disp_data_q, disp_data_d;
  logic           disp_valid_q, disp_valid_d;
  logic           rd_err_q, rd_err_d;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    to_cnt_d     = to_cnt_q;
    dbg_addr_d   = dbg_addr_q;
    disp_idx_d   = disp_idx_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    rd_err_d     = rd_err_q;
    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          pending_d = 1'b0;
          if (target_q == 5'd0) begin
            // x0 is hardwired zero: display it without touching the port.
            disp_idx_d   = 5'd0;
            disp_data_d  = 32'd0;
            disp_valid_d = 1'b1;
          end else begin
            dbg_addr_d = target_q;
            to_cnt_d   = '0;
            state_d    = StReq;
          end
        end
      end
      StReq: begin
        if (dbg_ack) begin
          disp_data_d  = dbg_data;
          disp_idx_d   = dbg_addr_q;
          disp_valid_d = 1'b1;
          rd_err_d     = 1'b0;
          state_d      = StIdle;
        end else if (to_cnt_q == ToMax) begin
          rd_err_d = 1'b1;
          state_d  = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // A new refresh event outranks the clear so it is never lost.
    if (refresh_set) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pending_q    <= 1'b1;
      target_q     <= '0;
      to_cnt_q     <= '0;
      dbg_addr_q   <= '0;
      disp_idx_q   <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      target_q     <= target_d;
      to_cnt_q     <= to_cnt_d;
      dbg_addr_q   <= dbg_addr_d;
      disp_idx_q   <= disp_idx_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      rd_err_q     <= rd_err_d;
    end
  end

  assign dbg_req    = (state_q == StReq);
  assign dbg_addr   = dbg_addr_q;
  assign disp_idx   = disp_idx_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_regfile_view_ctrl.sv
// Self-checking bench for regfile_view_ctrl: a register-file responder model checks every
// read transaction, and directed/randomized phases check selection, scan and timeout rules.
module tb_regfile_view_ctrl;

  localparam int unsigned SCAN_DIV    = 8;
  localparam int unsigned DEB_CYCLES  = 4;
  localparam int unsigned ACK_TIMEOUT = 4;
  localparam int          NEVER       = 99;

  logic        clk;
  logic        rst_n;
  logic [4:0]  switches;
  logic        mode_auto;
  logic        dbg_req;
  logic [4:0]  dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_data;
  logic [4:0]  disp_idx;
  logic [31:0] disp_data;
  logic        disp_valid;
  logic        rd_err;

  regfile_view_ctrl #(
    .SCAN_DIV   (SCAN_DIV),
    .DEB_CYCLES (DEB_CYCLES),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .switches  (switches),
    .mode_auto (mode_auto),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_ack   (dbg_ack),
    .dbg_data  (dbg_data),
    .disp_idx  (disp_idx),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .rd_err    (rd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Register-file model and responder controls.
  logic [31:0] regs [32];
  int          ack_lat;
  bit          spur_en;

  // Transaction monitor state.
  int          cyc = 0;
  bit          prev_req, prev_valid;
  logic [4:0]  prev_idx;
  int          req_len, last_len;
  logic [4:0]  req_addr;
  bit          ack_pend, to_pend, spur_pend;
  logic [4:0]  ack_addr, sv_idx;
  logic [31:0] ack_val, sv_data, junk;
  bit          start_flag;
  logic [4:0]  start_addr;
  int          n_req_rise = 0;
  int          n_req0 = 0;
  int          reads_of [32];
  int          log_addr [$];
  int          log_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    start_flag = 1'b0;
    if (!rst_n) begin
      prev_req   = 1'b0;
      prev_valid = 1'b0;
      prev_idx   = '0;
      req_len    = 0;
      ack_pend   = 1'b0;
      to_pend    = 1'b0;
      spur_pend  = 1'b0;
      dbg_ack    = 1'b0;
      dbg_data   = '0;
    end else begin
      // Consequences of what was presented at the previous edge.
      if (ack_pend) begin
        check("ack_req_drop", dbg_req, 0);
        check("ack_idx", disp_idx, ack_addr);
        check("ack_data", disp_data, ack_val);
        check("ack_valid", disp_valid, 1);
        check("ack_err_clr", rd_err, 0);
      end
      if (to_pend) begin
        check("to_req_drop", dbg_req, 0);
        check("to_err_set", rd_err, 1);
        check("to_idx_hold", disp_idx, sv_idx);
        check("to_data_hold", disp_data, sv_data);
      end
      if (spur_pend) check("idle_ack_ignored", disp_data == junk, 0);

      if (dbg_req && !prev_req) begin
        req_len    = 1;
        req_addr   = dbg_addr;
        n_req_rise++;
        if (dbg_addr == 5'd0) n_req0++;
        start_flag = 1'b1;
        start_addr = dbg_addr;
      end else if (dbg_req) begin
        req_len++;
        check("addr_stable", dbg_addr, req_addr);
      end else if (prev_req) begin
        last_len = req_len;
      end
      if (!dbg_req && disp_valid && disp_idx == 5'd0 && (!prev_valid || prev_idx != 5'd0)
          && !ack_pend) begin
        start_flag = 1'b1;
        start_addr = 5'd0;
      end
      if (start_flag) begin
        reads_of[start_addr]++;
        log_addr.push_back(int'(start_addr));
        log_cyc.push_back(cyc);
      end

      // Drive the port for the coming edge.
      ack_pend  = 1'b0;
      to_pend   = 1'b0;
      spur_pend = 1'b0;
      dbg_ack   = 1'b0;
      dbg_data  = $urandom;
      if (dbg_req && req_len > ack_lat) begin
        dbg_ack  = 1'b1;
        dbg_data = regs[dbg_addr];
        ack_pend = 1'b1;
        ack_addr = dbg_addr;
        ack_val  = regs[dbg_addr];
      end else if (dbg_req && req_len >= int'(ACK_TIMEOUT)) begin
        to_pend = 1'b1;
        sv_idx  = disp_idx;
        sv_data = disp_data;
      end else if (!dbg_req && spur_en && $urandom_range(0, 3) == 0) begin
        junk      = 32'hF00D_0000 | 32'($urandom_range(0, 65535));
        dbg_ack   = 1'b1;
        dbg_data  = junk;
        spur_pend = 1'b1;
      end
      prev_req   = dbg_req;
      prev_valid = disp_valid;
      prev_idx   = disp_idx;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_start(input logic [4:0] addr, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (start_flag && start_addr == addr) ok = 1'b1;
    end
  endtask

  task automatic wait_disp(input logic [4:0] idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (disp_valid && disp_idx == idx) ok = 1'b1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req"}, dbg_req, 0);
    check({tag, "_addr"}, dbg_addr, 0);
    check({tag, "_idx"}, disp_idx, 0);
    check({tag, "_data"}, disp_data, 0);
    check({tag, "_valid"}, disp_valid, 0);
    check({tag, "_err"}, rd_err, 0);
  endtask

  initial begin
    bit          ok, found;
    int          base, k;
    int          snap [32];
    bit          accepted [32];
    logic [4:0]  v, last_v, fv;
    int          run, len;
    logic [31:0] newval;

    for (int i = 0; i < 32; i++) begin
      regs[i]     = (i == 0) ? 32'd0 : ($urandom & 32'h7FFF_FFFF);
      reads_of[i] = 0;
    end
    rst_n     = 1'b0;
    switches  = '0;
    mode_auto = 1'b0;
    ack_lat   = 0;
    spur_en   = 1'b0;
    step(3);
    check_outputs_zero("reset");

    // Reset release: x0 displayed without a port request.
    rst_n = 1'b1;
    base  = n_req_rise;
    step(20);
    check("boot_idx", disp_idx, 0);
    check("boot_data", disp_data, 0);
    check("boot_valid", disp_valid, 1);
    check("boot_noreq", n_req_rise - base, 0);

    // Manual select of r5 and a short glitch to r6.
    regs[5]  = 32'hDEAD_BEEF;
    switches = 5'd5;
    wait_start(5'd5, 30, ok);
    check("r5_start", ok, 1);
    check("r5_addr", dbg_addr, 5);
    wait_disp(5'd5, 10, ok);
    check("r5_disp", ok, 1);
    check("r5_data", disp_data, 32'hDEAD_BEEF);
    base     = reads_of[6];
    switches = 5'd6;
    step(2);
    switches = 5'd5;
    step(30);
    check("glitch_no_r6", reads_of[6] - base, 0);
    check("glitch_idx", disp_idx, 5);

    // Timeout, then recovery on the next acked read.
    ack_lat = NEVER;
    wait_start(5'd5, 20, ok);
    check("to_start", ok, 1);
    step(6);
    check("to_req_len", last_len, ACK_TIMEOUT);
    check("to_err", rd_err, 1);
    check("to_idx", disp_idx, 5);
    check("to_data", disp_data, 32'hDEAD_BEEF);
    newval   = $urandom & 32'h7FFF_FFFF;
    regs[5]  = newval;
    ack_lat  = 0;
    wait_start(5'd5, 20, ok);
    check("rec_start", ok, 1);
    step(2);
    check("rec_err", rd_err, 0);
    check("rec_data", disp_data, newval);

    // Selection changes 3 -> 9 at varying points around a slow read of 3.
    for (int off = 0; off < 8; off++) begin
      ack_lat  = 0;
      switches = 5'd3;
      wait_disp(5'd3, 40, ok);
      check("sel3_disp", ok, 1);
      ack_lat = 3;
      wait_start(5'd3, 20, ok);
      check("sel3_start", ok, 1);
      step(off);
      switches = 5'd9;
      wait_disp(5'd9, 40, ok);
      check("sel9_disp", ok, 1);
      check("sel9_data", disp_data, regs[9]);
    end

    // Auto scan from 30: 30, 31, 0, 1 at 8-cycle spacing.
    ack_lat  = 0;
    switches = 5'd30;
    wait_disp(5'd30, 40, ok);
    check("auto_pre", ok, 1);
    wait_start(5'd30, 20, ok);
    step(1);
    log_addr.delete();
    log_cyc.delete();
    mode_auto = 1'b1;
    step(45);
    found = 1'b0;
    k     = 0;
    for (int i = 1; i + 2 < log_addr.size(); i++) begin
      if (!found && log_addr[i] == 31) begin
        found = 1'b1;
        k     = i;
      end
    end
    check("auto_found31", found, 1);
    if (found) begin
      check("auto_prev30", log_addr[k-1], 30);
      check("auto_gap30", log_cyc[k] - log_cyc[k-1], SCAN_DIV);
      check("auto_next0", log_addr[k+1], 0);
      check("auto_gap0", log_cyc[k+1] - log_cyc[k], SCAN_DIV);
      check("auto_next1", log_addr[k+2], 1);
      check("auto_gap1", log_cyc[k+2] - log_cyc[k+1], SCAN_DIV);
    end
    mode_auto = 1'b0;
    step(5);

    // Randomized manual selection: only values held DEB_CYCLES cycles may be read.
    spur_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      accepted[i] = 1'b0;
      snap[i]     = reads_of[i];
    end
    accepted[30] = 1'b1;
    last_v       = 5'd30;
    run          = 100;
    for (int it = 0; it < 30; it++) begin
      v       = 5'($urandom_range(0, 31));
      len     = $urandom_range(1, 7);
      ack_lat = $urandom_range(0, 5);
      for (int c = 0; c < len; c++) begin
        switches = v;
        run      = (v == last_v) ? run + 1 : 1;
        last_v   = v;
        if (run >= int'(DEB_CYCLES)) accepted[v] = 1'b1;
        step(1);
      end
    end
    for (int i = 0; i < 32; i++) begin
      if (reads_of[i] != snap[i]) check("deb_read_legal", accepted[i], 1);
    end
    spur_en  = 1'b0;
    ack_lat  = 0;
    fv       = 5'($urandom_range(1, 31));
    switches = fv;
    step(20);
    wait_start(fv, 20, ok);
    check("rand_final_start", ok, 1);
    step(2);
    check("rand_final_idx", disp_idx, fv);
    check("rand_final_data", disp_data, regs[fv]);
    check("rand_final_err", rd_err, 0);

    // Asynchronous reset in the middle of a request.
    ack_lat = NEVER;
    wait_start(fv, 20, ok);
    check("mid_req_start", ok, 1);
    check("mid_req_high", dbg_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    switches = 5'd0;
    ack_lat  = 0;
    step(3);
    rst_n = 1'b1;
    base  = n_req_rise;
    step(20);
    check("reboot_idx", disp_idx, 0);
    check("reboot_data", disp_data, 0);
    check("reboot_valid", disp_valid, 1);
    check("reboot_noreq", n_req_rise - base, 0);
    check("never_req_x0", n_req0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_view_ctrl.md
REGFILE_VIEW_CTRL -- requirements
Module: regfile_view_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000000, SHALL set the clock cycles per refresh/scan tick (legal range 2 and above).
REQ-002 Parameter DEB_CYCLES, default 1000000, SHALL set the consecutive stable cycles required to accept a new switch value (legal range 1 and above).
REQ-003 Parameter ACK_TIMEOUT, default 16, SHALL set the maximum cycles dbg_req waits for dbg_ack.
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 switches  input  5  asynchronous register-number selection from the board switches.
REQ-007 mode_auto  input  1  asynchronous mode select: 0 = manual, 1 = auto-scan.
REQ-008 dbg_req  output  1  read request to the register-file debug read port.
REQ-009 dbg_addr  output  5  register number being read.
REQ-010 dbg_ack  input  1  port acknowledge; dbg_data is valid in the same cycle.
REQ-011 dbg_data  input  32  register contents.
REQ-012 disp_idx  output  5  register number of the displayed value.
REQ-013 disp_data  output  32  displayed register value.
REQ-014 disp_valid  output  1  set after the first completed read and held until reset.
REQ-015 rd_err  output  1  sticky timeout flag.

Function
REQ-016 switches and mode_auto SHALL each pass through a 2-flop synchronizer before any use.
REQ-017 Debounce: the synchronized switches SHALL be copied to sel_idx only after holding one value for DEB_CYCLES consecutive cycles; any change restarts the count.
REQ-018 A free-running tick counter SHALL count 0..SCAN_DIV-1, wrap to 0, and assert tick for one cycle on wrap.
REQ-019 Manual mode: target SHALL equal sel_idx; a change of sel_idx or a tick SHALL set the refresh_pending flag.
REQ-020 Auto mode: each tick SHALL advance target by 1, modulo 32 (31 wraps to 0), and set refresh_pending.
REQ-021 A 0-to-1 transition of synchronized mode_auto SHALL load target from sel_idx, set refresh_pending, and restart the tick counter at 0.
REQ-022 FSM states SHALL be IDLE and REQ.
REQ-023 In IDLE with refresh_pending and target == 0, the block SHALL load disp_idx = 0 and disp_data = 0, set disp_valid, clear refresh_pending, and issue no request.
REQ-024 In IDLE with refresh_pending and target != 0, the block SHALL latch dbg_addr = target, clear refresh_pending, and enter REQ.
REQ-025 In REQ, dbg_req SHALL be 1 and dbg_addr SHALL stay stable until exit.
REQ-026 An ack in REQ SHALL capture dbg_data into disp_data and dbg_addr into disp_idx, set disp_valid, clear rd_err, drop dbg_req in the next cycle, and return to IDLE.
REQ-027 After ACK_TIMEOUT REQ cycles without an ack, the block SHALL drop dbg_req, set rd_err, leave the disp_* outputs unchanged, and return to IDLE.
REQ-028 A target change or tick during REQ SHALL only set refresh_pending; it SHALL not alter dbg_addr. The new read SHALL start from IDLE.
REQ-029 dbg_ack while in IDLE SHALL be ignored.
REQ-030 Read latency: dbg_req SHALL rise 1 cycle after refresh_pending sets, and disp_data SHALL update on the clock edge that samples dbg_ack.

Reset
REQ-031 While rst_n = 0, all outputs SHALL be 0, the FSM SHALL be IDLE, all counters, sel_idx, target and the synchronizers SHALL be 0, and refresh_pending SHALL be 1 so that a read of x0 follows reset.
REQ-032 Reset asserted during REQ SHALL drop dbg_req immediately (asynchronously) with no capture.

Verification (SCAN_DIV=8, DEB_CYCLES=4, ACK_TIMEOUT=4)
REQ-033 Release reset, mode_auto=0, switches=0 -> disp_idx=0, disp_data=0, disp_valid=1 with no dbg_req pulse.
REQ-034 switches=5 held for 4 or more post-sync cycles, port acks in 1 cycle with 0xDEADBEEF -> dbg_addr=5, disp_idx=5, disp_data=0xDEADBEEF; a 2-cycle glitch to 6 -> no read of 6.
REQ-035 mode_auto=1 with sel_idx=30, immediate acks -> successive reads of 30, 31, 0, 1 spaced 8 cycles apart; reg 0 is read without a request.
REQ-036 Port never acks -> dbg_req high for exactly 4 cycles, then rd_err=1 and disp_* unchanged; the next acked read -> rd_err=0.
REQ-037 sel_idx changes 3 to 9 while a read of 3 waits 3 cycles -> dbg_addr stays 3 until the ack, then a read of 9 follows.
REQ-038 rst_n pulsed low mid-REQ -> dbg_req=0 and disp_valid=0 immediately; after release, the REQ-033 behaviour repeats.
